// File: rtl/mmio_fabric_if.sv
// Upstream MMIO request/response bus between the fpro bridge and the slot fabric.
interface mmio_fabric_if #(
    parameter int unsigned ADDR_W = 21,
    parameter int unsigned DATA_W = 32
);
    logic              mmio_cs;
    logic [ADDR_W-1:0] mmio_address;
    logic [DATA_W-1:0] mmio_write_data;
    logic              mmio_write;
    logic              mmio_read;
    logic [DATA_W-1:0] mmio_read_data;
    logic              mmio_ready;
    logic              mmio_error;
    logic              mmio_busy;

    modport master (
        output mmio_cs, mmio_address, mmio_write_data, mmio_write, mmio_read,
        input  mmio_read_data, mmio_ready, mmio_error, mmio_busy
    );

    modport slave (
        input  mmio_cs, mmio_address, mmio_write_data, mmio_write, mmio_read,
        output mmio_read_data, mmio_ready, mmio_error, mmio_busy
    );
endinterface

// File: rtl/mmio_fabric.sv
// MMIO slot fabric: registered request stage, per-slot wait states, bus timeout,
// error reporting and an internal status slot with error counters.
module mmio_fabric #(
    parameter int unsigned          NUM_SLOTS   = 64,
    parameter int unsigned          REG_W       = 5,
    parameter int unsigned          ADDR_W      = 21,
    parameter int unsigned          DATA_W      = 32,
    parameter logic [NUM_SLOTS-1:0] SLOT_MASK   = NUM_SLOTS'(64'hF),
    parameter int unsigned          TIMEOUT     = 16,
    parameter int unsigned          FABRIC_SLOT = NUM_SLOTS - 1
) (
    input  logic                        clock,
    input  logic                        reset,
    mmio_fabric_if.slave                bus,
    output logic [NUM_SLOTS-1:0]        slot_cs,
    output logic [REG_W-1:0]            slot_reg_addr,
    output logic [DATA_W-1:0]           slot_write_data,
    output logic [NUM_SLOTS-1:0]        slot_write,
    output logic [NUM_SLOTS-1:0]        slot_read,
    input  logic [NUM_SLOTS*DATA_W-1:0] slot_read_data,
    input  logic [NUM_SLOTS-1:0]        slot_ready
);
    localparam int unsigned SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int unsigned SLOT_N = 1 << SLOT_W;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
    // Mask padded to the full slot index range so unused indices read as unmapped
    localparam logic [SLOT_N-1:0] POP_MASK = SLOT_N'(SLOT_MASK);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]           state, state_nx;
    logic [SLOT_W-1:0]    req_slot, req_slot_nx;
    logic [REG_W-1:0]     req_reg_nx;
    logic [DATA_W-1:0]    req_wd_nx;
    logic [ADDR_W-1:0]    req_addr, req_addr_nx;
    logic                 req_rd, req_rd_nx, req_int, req_int_nx;
    logic [CNT_W-1:0]     cnt, cnt_nx;
    logic [DATA_W-1:0]    rdata_nx;
    logic                 ready_nx, error_nx;
    logic [NUM_SLOTS-1:0] cs_nx, wr_nx, rd_nx;

    logic [15:0]          err_cnt;
    logic [16:0]          cnt_sum;
    logic [ADDR_W-1:0]    last_addr, err_addr;
    logic                 ovr_flag, tmo_flag, unm_flag;
    logic                 ovr_ev, acc_err_ev, tmo_ev, unm_ev, clear_ev;

    logic [SLOT_W-1:0]    in_slot;
    logic                 in_int, in_pop, in_bad;
    logic [NUM_SLOTS-1:0] in_onehot;
    logic [SLOT_N-1:0]    rdy_pad;
    logic                 sel_ready;
    logic [DATA_W-1:0]    sel_data, stat_rd;

    assign in_slot   = bus.mmio_address[REG_W+SLOT_W-1:REG_W];
    assign in_int    = (in_slot == SLOT_W'(FABRIC_SLOT));
    assign in_pop    = POP_MASK[in_slot];
    assign in_bad    = (bus.mmio_read == bus.mmio_write);
    assign in_onehot = NUM_SLOTS'(SLOT_N'(1) << in_slot);
    assign rdy_pad   = SLOT_N'(slot_ready);
    assign sel_ready = rdy_pad[req_slot];
    assign sel_data  = slot_read_data[32'(req_slot)*DATA_W +: DATA_W];
    assign ovr_ev    = bus.mmio_cs && (state != S_IDLE);
    assign cnt_sum   = {1'b0, err_cnt} + 17'(ovr_ev) + 17'(acc_err_ev);

    // Status slot read mux
    always_comb begin
        stat_rd = '0;
        case (slot_reg_addr)
            REG_W'(0): stat_rd = DATA_W'(err_cnt);
            REG_W'(1): stat_rd = DATA_W'(last_addr);
            REG_W'(2): stat_rd = DATA_W'({ovr_flag, tmo_flag, unm_flag});
            default:   stat_rd = '0;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx    = state;
        req_slot_nx = req_slot;
        req_reg_nx  = slot_reg_addr;
        req_wd_nx   = slot_write_data;
        req_addr_nx = req_addr;
        req_rd_nx   = req_rd;
        req_int_nx  = req_int;
        cnt_nx      = cnt;
        rdata_nx    = bus.mmio_read_data;
        ready_nx    = 1'b0;
        error_nx    = 1'b0;
        cs_nx       = '0;
        wr_nx       = '0;
        rd_nx       = '0;
        acc_err_ev  = 1'b0;
        tmo_ev      = 1'b0;
        unm_ev      = 1'b0;
        clear_ev    = 1'b0;
        err_addr    = req_addr;

        unique case (state)
            S_IDLE: begin
                if (bus.mmio_cs) begin
                    req_slot_nx = in_slot;
                    req_reg_nx  = bus.mmio_address[REG_W-1:0];
                    req_wd_nx   = bus.mmio_write_data;
                    req_addr_nx = bus.mmio_address;
                    req_rd_nx   = bus.mmio_read;
                    req_int_nx  = in_int;
                    if (in_bad || (!in_int && !in_pop)) begin
                        state_nx   = S_DONE;
                        ready_nx   = 1'b1;
                        error_nx   = 1'b1;
                        rdata_nx   = '1;
                        acc_err_ev = 1'b1;
                        unm_ev     = !in_int && !in_pop;
                        err_addr   = bus.mmio_address;
                    end else begin
                        state_nx = S_ACCESS;
                        if (!in_int) begin
                            cs_nx = in_onehot;
                            rd_nx = bus.mmio_read  ? in_onehot : '0;
                            wr_nx = bus.mmio_write ? in_onehot : '0;
                        end
                    end
                end
            end
            S_ACCESS: begin
                if (req_int) begin
                    state_nx = S_DONE;
                    ready_nx = 1'b1;
                    if (req_rd) rdata_nx = stat_rd;
                    else        clear_ev = (slot_reg_addr == REG_W'(0));
                end else if (sel_ready) begin
                    state_nx = S_DONE;
                    ready_nx = 1'b1;
                    if (req_rd) rdata_nx = sel_data;
                end else begin
                    state_nx = S_WAIT;
                    cnt_nx   = CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (sel_ready) begin
                    state_nx = S_DONE;
                    ready_nx = 1'b1;
                    if (req_rd) rdata_nx = sel_data;
                end else if (cnt == CNT_W'(TIMEOUT)) begin
                    state_nx   = S_DONE;
                    ready_nx   = 1'b1;
                    error_nx   = 1'b1;
                    rdata_nx   = '1;
                    acc_err_ev = 1'b1;
                    tmo_ev     = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State, request and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state              <= S_IDLE;
            req_slot           <= '0;
            slot_reg_addr      <= '0;
            slot_write_data    <= '0;
            req_addr           <= '0;
            req_rd             <= 1'b0;
            req_int            <= 1'b0;
            cnt                <= '0;
            slot_cs            <= '0;
            slot_write         <= '0;
            slot_read          <= '0;
            bus.mmio_read_data <= '0;
            bus.mmio_ready     <= 1'b0;
            bus.mmio_error     <= 1'b0;
            bus.mmio_busy      <= 1'b0;
        end else begin
            state              <= state_nx;
            req_slot           <= req_slot_nx;
            slot_reg_addr      <= req_reg_nx;
            slot_write_data    <= req_wd_nx;
            req_addr           <= req_addr_nx;
            req_rd             <= req_rd_nx;
            req_int            <= req_int_nx;
            cnt                <= cnt_nx;
            slot_cs            <= cs_nx;
            slot_write         <= wr_nx;
            slot_read          <= rd_nx;
            bus.mmio_read_data <= rdata_nx;
            bus.mmio_ready     <= ready_nx;
            bus.mmio_error     <= error_nx;
            bus.mmio_busy      <= (state_nx != S_IDLE);
        end
    end

    // Error counters and sticky flags; a clearing write beats a same-cycle error
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_cnt   <= '0;
            last_addr <= '0;
            ovr_flag  <= 1'b0;
            tmo_flag  <= 1'b0;
            unm_flag  <= 1'b0;
        end else if (clear_ev) begin
            err_cnt   <= '0;
            last_addr <= '0;
            ovr_flag  <= 1'b0;
            tmo_flag  <= 1'b0;
            unm_flag  <= 1'b0;
        end else begin
            if (ovr_ev || acc_err_ev) begin
                err_cnt   <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
                last_addr <= acc_err_ev ? err_addr : bus.mmio_address;
            end
            ovr_flag <= ovr_flag | ovr_ev;
            tmo_flag <= tmo_flag | tmo_ev;
            unm_flag <= unm_flag | unm_ev;
        end
    end
endmodule

// File: tb/tb_mmio_fabric.sv
// Directed bench for mmio_fabric: vector table plus overrun and mid-access reset sequences.
module tb_mmio_fabric;
    localparam int NEVER = 100000;

    logic           clock;
    logic           reset;
    logic [63:0]    slot_cs, slot_write, slot_read, slot_ready;
    logic [4:0]     slot_reg_addr;
    logic [31:0]    slot_write_data;
    logic [2047:0]  slot_read_data;

    int n_pass  = 0;
    int n_total = 0;
    int tgt     = 0;
    int dly     = NEVER;
    int k       = NEVER;

    mmio_fabric_if #(.ADDR_W(21), .DATA_W(32)) bus ();

    mmio_fabric dut (
        .clock           (clock),
        .reset           (reset),
        .bus             (bus),
        .slot_cs         (slot_cs),
        .slot_reg_addr   (slot_reg_addr),
        .slot_write_data (slot_write_data),
        .slot_write      (slot_write),
        .slot_read       (slot_read),
        .slot_read_data  (slot_read_data),
        .slot_ready      (slot_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Peripheral model: target slot answers dly cycles after its strobe; all others always ready
    always @(negedge clock) begin
        if (|slot_cs) k = 0;
        else if (k < NEVER) k = k + 1;
        slot_ready      = '1;
        slot_ready[tgt] = (k == dly);
    end

    typedef struct {
        logic [20:0] addr;
        logic        rd;
        logic        wr;
        logic [31:0] wd;
        int          tgt;
        int          dly;
        logic [31:0] sdata;
        int          lat;
        logic        err;
        logic [31:0] rdata;
        logic [63:0] cs;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic do_req(input logic [20:0] addr, input logic rd, input logic wr,
                          input logic [31:0] wd, output int lat, output logic err,
                          output logic [31:0] rdata, output logic [63:0] c_cs,
                          output logic [63:0] c_rw, output logic [4:0] c_reg,
                          output logic [31:0] c_wd);
        @(negedge clock);
        bus.mmio_cs         = 1'b1;
        bus.mmio_address    = addr;
        bus.mmio_read       = rd;
        bus.mmio_write      = wr;
        bus.mmio_write_data = wd;
        lat = -1;
        err = 1'bx;
        rdata = 'x;
        c_cs = 'x; c_rw = 'x; c_reg = 'x; c_wd = 'x;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (i == 1) begin
                bus.mmio_cs = 1'b0;
                c_cs  = slot_cs;
                c_rw  = (wr && !rd) ? slot_write : slot_read;
                c_reg = slot_reg_addr;
                c_wd  = slot_write_data;
            end
            if (bus.mmio_ready) begin
                lat   = i;
                err   = bus.mmio_error;
                rdata = bus.mmio_read_data;
                break;
            end
        end
    endtask

    task automatic set_slot(input int t, input int d, input logic [31:0] sd);
        tgt = t;
        dly = d;
        slot_read_data = '0;
        slot_read_data[t*32 +: 32] = sd;
    endtask

    task automatic stat_read(input string name, input logic [4:0] r, input logic [31:0] exp);
        int lat; logic err; logic [31:0] rd; logic [63:0] c_cs, c_rw; logic [4:0] c_reg; logic [31:0] c_wd;
        do_req({16'h3F, r}, 1'b1, 1'b0, 32'h0, lat, err, rd, c_cs, c_rw, c_reg, c_wd);
        chk({name, "_lat"}, 64'(lat), 64'd2);
        chk(name, 64'(rd), 64'(exp));
    endtask

    int          lat;
    logic        err;
    logic [31:0] rdata, c_wd;
    logic [63:0] c_cs, c_rw;
    logic [4:0]  c_reg;
    int          seen;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        bus.mmio_cs = 1'b0; bus.mmio_address = '0; bus.mmio_read = 1'b0;
        bus.mmio_write = 1'b0; bus.mmio_write_data = '0;
        slot_read_data = '0;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_busy",  64'(bus.mmio_busy), 64'd0);
        chk("rst_ready", 64'(bus.mmio_ready), 64'd0);
        chk("rst_rdata", 64'(bus.mmio_read_data), 64'd0);
        chk("rst_cs",    slot_cs, 64'd0);
        reset = 1'b1;

        //           addr     rd    wr    wd      tgt dly    sdata          lat err   rdata          cs
        tbl.push_back('{21'h020, 1'b1, 1'b0, 32'h0,  1, 0,     32'h0000_1234, 2,  1'b0, 32'h0000_1234, 64'h2});
        tbl.push_back('{21'h002, 1'b0, 1'b1, 32'hAB, 0, 3,     32'h0,         5,  1'b0, 32'h0000_1234, 64'h1});
        tbl.push_back('{21'h0E0, 1'b1, 1'b0, 32'h0,  0, NEVER, 32'h0,         1,  1'b1, 32'hFFFF_FFFF, 64'h0});
        tbl.push_back('{21'h7E0, 1'b1, 1'b0, 32'h0,  0, NEVER, 32'h0,         2,  1'b0, 32'h1,         64'h0});
        tbl.push_back('{21'h7E1, 1'b1, 1'b0, 32'h0,  0, NEVER, 32'h0,         2,  1'b0, 32'hE0,        64'h0});
        tbl.push_back('{21'h040, 1'b1, 1'b0, 32'h0,  2, NEVER, 32'h5A5A_5A5A, 18, 1'b1, 32'hFFFF_FFFF, 64'h4});
        tbl.push_back('{21'h7E2, 1'b1, 1'b0, 32'h0,  0, NEVER, 32'h0,         2,  1'b0, 32'h3,         64'h0});
        tbl.push_back('{21'h7E0, 1'b1, 1'b0, 32'h0,  0, NEVER, 32'h0,         2,  1'b0, 32'h2,         64'h0});
        tbl.push_back('{21'h7E1, 1'b1, 1'b0, 32'h0,  0, NEVER, 32'h0,         2,  1'b0, 32'h40,        64'h0});
        tbl.push_back('{21'h020, 1'b1, 1'b1, 32'h0,  1, 0,     32'h0000_1234, 1,  1'b1, 32'hFFFF_FFFF, 64'h0});
        tbl.push_back('{21'h024, 1'b0, 1'b0, 32'h0,  1, 0,     32'h0000_1234, 1,  1'b1, 32'hFFFF_FFFF, 64'h0});
        tbl.push_back('{21'h7E1, 1'b0, 1'b1, 32'h5,  0, NEVER, 32'h0,         2,  1'b0, 32'hFFFF_FFFF, 64'h0});
        tbl.push_back('{21'h7E0, 1'b1, 1'b0, 32'h0,  0, NEVER, 32'h0,         2,  1'b0, 32'h4,         64'h0});
        tbl.push_back('{21'h7E1, 1'b1, 1'b0, 32'h0,  0, NEVER, 32'h0,         2,  1'b0, 32'h24,        64'h0});
        tbl.push_back('{21'h7E5, 1'b1, 1'b0, 32'h0,  0, NEVER, 32'h0,         2,  1'b0, 32'h0,         64'h0});
        tbl.push_back('{21'h061, 1'b1, 1'b0, 32'h0,  3, 1,     32'hCAFE_F00D, 3,  1'b0, 32'hCAFE_F00D, 64'h8});

        foreach (tbl[i]) begin
            set_slot(tbl[i].tgt, tbl[i].dly, tbl[i].sdata);
            do_req(tbl[i].addr, tbl[i].rd, tbl[i].wr, tbl[i].wd, lat, err, rdata, c_cs, c_rw, c_reg, c_wd);
            chk($sformatf("v%0d_lat", i),   64'(lat),   64'(tbl[i].lat));
            chk($sformatf("v%0d_err", i),   64'(err),   64'(tbl[i].err));
            chk($sformatf("v%0d_rdata", i), 64'(rdata), 64'(tbl[i].rdata));
            chk($sformatf("v%0d_cs", i),    c_cs,       tbl[i].cs);
            chk($sformatf("v%0d_rw", i),    c_rw,       tbl[i].cs);
            if (tbl[i].cs != 64'h0) chk($sformatf("v%0d_reg", i), 64'(c_reg), 64'(tbl[i].addr[4:0]));
            if (tbl[i].cs != 64'h0 && tbl[i].wr) chk($sformatf("v%0d_wd", i), 64'(c_wd), 64'(tbl[i].wd));
        end

        // Clear counters, then an overrun while a slot is waiting
        set_slot(0, NEVER, 32'h0);
        do_req(21'h7E0, 1'b0, 1'b1, 32'h0, lat, err, rdata, c_cs, c_rw, c_reg, c_wd);
        chk("clr1_lat", 64'(lat), 64'd2);
        stat_read("clr1_r0", 5'd0, 32'h0);
        stat_read("clr1_r2", 5'd2, 32'h0);

        set_slot(0, 3, 32'h55);
        @(negedge clock);
        bus.mmio_cs = 1'b1; bus.mmio_address = 21'h000; bus.mmio_read = 1'b1; bus.mmio_write = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (i == 1) bus.mmio_cs = 1'b0;
            if (i == 3) begin bus.mmio_cs = 1'b1; bus.mmio_address = 21'h060; end
            if (i == 4) bus.mmio_cs = 1'b0;
            if (bus.mmio_ready) begin
                lat = i; err = bus.mmio_error; rdata = bus.mmio_read_data;
                break;
            end
        end
        chk("ovr_lat",   64'(lat),   64'd5);
        chk("ovr_err",   64'(err),   64'd0);
        chk("ovr_rdata", 64'(rdata), 64'h55);
        @(negedge clock);
        chk("ovr_idle", 64'(bus.mmio_busy), 64'd0);
        stat_read("ovr_r2", 5'd2, 32'h4);
        stat_read("ovr_r0", 5'd0, 32'h1);
        stat_read("ovr_r1", 5'd1, 32'h60);
        do_req(21'h7E0, 1'b0, 1'b1, 32'h0, lat, err, rdata, c_cs, c_rw, c_reg, c_wd);
        chk("clr2_err", 64'(err), 64'd0);
        stat_read("clr2_r0", 5'd0, 32'h0);
        stat_read("clr2_r1", 5'd1, 32'h0);
        stat_read("clr2_r2", 5'd2, 32'h0);

        // Reset while waiting on a slot that never answers
        set_slot(2, NEVER, 32'h0);
        @(negedge clock);
        bus.mmio_cs = 1'b1; bus.mmio_address = 21'h040; bus.mmio_read = 1'b1; bus.mmio_write = 1'b0;
        @(negedge clock);
        bus.mmio_cs = 1'b0;
        chk("rmid_cs_access", slot_cs, 64'h4);
        repeat (3) @(negedge clock);
        chk("rmid_busy_pre", 64'(bus.mmio_busy), 64'd1);
        reset = 1'b0;
        #1;
        chk("rmid_busy",  64'(bus.mmio_busy), 64'd0);
        chk("rmid_ready", 64'(bus.mmio_ready), 64'd0);
        chk("rmid_cs",    slot_cs | slot_read | slot_write, 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        seen = 0;
        repeat (25) begin
            @(negedge clock);
            if (bus.mmio_ready) seen++;
        end
        chk("rmid_no_ready", 64'(seen), 64'd0);
        set_slot(1, 0, 32'h0000_1234);
        do_req(21'h020, 1'b1, 1'b0, 32'h0, lat, err, rdata, c_cs, c_rw, c_reg, c_wd);
        chk("post_lat",   64'(lat),   64'd2);
        chk("post_err",   64'(err),   64'd0);
        chk("post_rdata", 64'(rdata), 64'h1234);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
